// File: rtl/rr_mux8to1_pkg.sv
// Shared constants and the rotate-and-priority-encode helper for the 8:1 round-robin mux.
package rr_mux8to1_pkg;

  localparam int unsigned NUM_SRC   = 8;
  localparam int unsigned SEL_W     = 3;
  localparam int unsigned DEF_WIDTH = 8;

  typedef struct packed {
    logic             any;
    logic [SEL_W-1:0] idx;
  } rr_pick_t;

  // First set request at or above ptr, wrapping past the top source back to 0.
  function automatic rr_pick_t rr_pick(input logic [NUM_SRC-1:0] req,
                                       input logic [SEL_W-1:0]   ptr);
    logic [2*NUM_SRC-1:0] dbl;
    logic [NUM_SRC-1:0]   rot;
    rr_pick_t             pick;
    dbl  = {req, req};
    rot  = dbl[ptr +: NUM_SRC];
    pick = '0;
    // Scan downward so the lowest rotated position wins.
    for (int k = NUM_SRC - 1; k >= 0; k--) begin
      if (rot[k]) begin
        pick.any = 1'b1;
        pick.idx = ptr + SEL_W'(k);
      end
    end
    return pick;
  endfunction

endpackage

// File: rtl/rr_mux8to1_arbiter8.sv
// Combinational round-robin arbiter: requests and pointer in, one-hot grant and index out.
module rr_arbiter8
  import rr_mux8to1_pkg::*;
(
  input  logic [NUM_SRC-1:0] i_valid,
  input  logic [SEL_W-1:0]   i_ptr,
  output logic [NUM_SRC-1:0] o_grant_c,
  output logic [SEL_W-1:0]   o_idx_c,
  output logic               o_any_c
);

  rr_pick_t w_pick;

  always_comb begin
    w_pick    = rr_pick(i_valid, i_ptr);
    o_any_c   = w_pick.any;
    o_idx_c   = w_pick.idx;
    o_grant_c = '0;
    if (w_pick.any) o_grant_c[w_pick.idx] = 1'b1;
  end

endmodule

// File: rtl/rr_mux8to1.sv
// Eight-source round-robin mux into a single registered output stage with valid/ready handshake.
module rr_mux8to1
  import rr_mux8to1_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH
)(
  input  logic                     clk,
  input  logic                     clrn,
  input  logic [NUM_SRC-1:0]       in_valid,
  input  logic [NUM_SRC*WIDTH-1:0] in_data,
  output logic [NUM_SRC-1:0]       in_ready,
  output logic                     out_valid,
  output logic [WIDTH-1:0]         out_data,
  output logic [SEL_W-1:0]         out_src,
  input  logic                     out_ready
);

  logic [SEL_W-1:0]   r_ptr;
  logic               r_out_valid;
  logic [WIDTH-1:0]   r_out_data;
  logic [SEL_W-1:0]   r_out_src;

  logic [NUM_SRC-1:0] w_grant;
  logic [SEL_W-1:0]   w_idx;
  logic               w_any;
  logic               w_load_en;
  logic               w_xfer;
  logic [WIDTH-1:0]   w_sel_data;

  rr_arbiter8 u_arb (
    .i_valid   (in_valid),
    .i_ptr     (r_ptr),
    .o_grant_c (w_grant),
    .o_idx_c   (w_idx),
    .o_any_c   (w_any)
  );

  // Output slot is free when empty or being drained this cycle; nothing is accepted in reset.
  assign w_load_en = (~r_out_valid | out_ready) & clrn;
  assign w_xfer    = w_load_en & w_any;
  assign in_ready  = w_grant & {NUM_SRC{w_load_en}};

  always_comb begin
    w_sel_data = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (w_idx == SEL_W'(i)) w_sel_data = in_data[i*WIDTH +: WIDTH];
    end
  end

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      r_ptr       <= '0;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_src   <= '0;
    end else if (w_xfer) begin
      r_ptr       <= w_idx + SEL_W'(1);
      r_out_valid <= 1'b1;
      r_out_data  <= w_sel_data;
      r_out_src   <= w_idx;
    end else if (out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign out_src   = r_out_src;

endmodule
